arm_execute_stage: RTL and testbench

- Execute stage of the 5-stage ARM-subset pipeline. Sits between the ID/EX register and the MEM stage.
- Selects forwarded operands and generates the second operand (Val2). Runs the ALU and computes NZCV flags and the branch target.
- Registers results into the EX/MEM pipeline register.
- ALU_res, SR_out, branch_address and B_out are combinational; all *_out MEM-side signals are registered.

---
 rtl/arm_execute_stage.sv | 146 ++++++++++++++
 tb/tb_arm_execute_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/arm_execute_stage.sv
// ARM-subset execute stage: forwarding, shifter/Val2, ALU with NZCV flags,
// branch target, and the EX/MEM pipeline register.
module arm_execute_stage #(
    parameter int REG_FILE_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pc_in,
    input  logic [31:0]               instruction_in,
    input  logic [31:0]               val_Rn_in,
    input  logic [31:0]               val_Rm_in,
    input  logic [31:0]               MEM_stage_val,
    input  logic [31:0]               WB_stage_val,
    input  logic [1:0]                sel_src1,
    input  logic [1:0]                sel_src2,
    input  logic [3:0]                EX_command,
    input  logic [3:0]                SR_in,
    input  logic                      imm,
    input  logic [11:0]               shifter_operand,
    input  logic [23:0]               signed_immediate,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic                      WB_en_in,
    input  logic                      B_in,
    input  logic [REG_FILE_DEPTH-1:0] dst_in,
    output logic [31:0]               ALU_res,
    output logic [3:0]                SR_out,
    output logic [31:0]               branch_address,
    output logic                      B_out,
    output logic [31:0]               pc_out,
    output logic [31:0]               instruction_out,
    output logic [31:0]               ALU_res_out,
    output logic [31:0]               val_Rm_out,
    output logic [REG_FILE_DEPTH-1:0] dst_out,
    output logic                      mem_read_out,
    output logic                      mem_write_out,
    output logic                      WB_en_out
);

    logic [31:0] op_a;
    logic [31:0] rm_fwd;
    logic [31:0] val2;
    logic [63:0] rot_imm;
    logic [63:0] rot_reg;
    logic [4:0]  sh_amt;
    logic [32:0] sum;
    logic        cin;

    always_comb begin
        unique case (sel_src1)
            2'b01:   op_a = MEM_stage_val;
            2'b10:   op_a = WB_stage_val;
            default: op_a = val_Rn_in;
        endcase
        unique case (sel_src2)
            2'b01:   rm_fwd = MEM_stage_val;
            2'b10:   rm_fwd = WB_stage_val;
            default: rm_fwd = val_Rm_in;
        endcase
    end

    // Rotates use a doubled word so amount 0 needs no special case.
    assign sh_amt  = shifter_operand[11:7];
    assign rot_imm = {24'b0, shifter_operand[7:0], 24'b0, shifter_operand[7:0]}
                     >> {shifter_operand[11:8], 1'b0};
    assign rot_reg = {rm_fwd, rm_fwd} >> sh_amt;

    always_comb begin
        val2 = rm_fwd;
        if (mem_read_in || mem_write_in) begin
            val2 = {20'b0, shifter_operand};
        end else if (imm) begin
            val2 = rot_imm[31:0];
        end else begin
            unique case (shifter_operand[6:5])
                2'b00:   val2 = rm_fwd << sh_amt;
                2'b01:   val2 = rm_fwd >> sh_amt;
                2'b10:   val2 = $unsigned($signed(rm_fwd) >>> sh_amt);
                default: val2 = rot_reg[31:0];
            endcase
        end
    end

    assign cin = SR_in[1];

    always_comb begin
        sum     = 33'b0;
        ALU_res = 32'b0;
        SR_out  = SR_in;
        unique case (EX_command)
            4'b0001: ALU_res = val2;
            4'b1001: ALU_res = ~val2;
            4'b0110: ALU_res = op_a & val2;
            4'b0111: ALU_res = op_a | val2;
            4'b1000: ALU_res = op_a ^ val2;
            4'b0010, 4'b0011: begin
                sum = {1'b0, op_a} + {1'b0, val2}
                    + {32'b0, (EX_command[0] & cin)};
                ALU_res   = sum[31:0];
                SR_out[1] = sum[32];
                SR_out[0] = (op_a[31] == val2[31]) && (sum[31] != op_a[31]);
            end
            4'b0100, 4'b0101: begin
                // A + ~B + 1 (SUB) or A + ~B + C (SBC); carry out is NOT borrow.
                sum = {1'b0, op_a} + {1'b0, ~val2}
                    + {32'b0, (EX_command[0] ? cin : 1'b1)};
                ALU_res   = sum[31:0];
                SR_out[1] = sum[32];
                SR_out[0] = (op_a[31] != val2[31]) && (sum[31] != op_a[31]);
            end
            default: ALU_res = 32'b0;
        endcase
        if (EX_command inside {4'b0001, 4'b1001, 4'b0010, 4'b0011,
                               4'b0100, 4'b0101, 4'b0110, 4'b0111,
                               4'b1000}) begin
            SR_out[3] = ALU_res[31];
            SR_out[2] = (ALU_res == 32'b0);
        end
    end

    assign branch_address = pc_in + {{6{signed_immediate[23]}}, signed_immediate, 2'b00};
    assign B_out          = B_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out          <= 32'b0;
            instruction_out <= 32'b0;
            ALU_res_out     <= 32'b0;
            val_Rm_out      <= 32'b0;
            dst_out         <= '0;
            mem_read_out    <= 1'b0;
            mem_write_out   <= 1'b0;
            WB_en_out       <= 1'b0;
        end else begin
            pc_out          <= pc_in;
            instruction_out <= instruction_in;
            ALU_res_out     <= ALU_res;
            val_Rm_out      <= rm_fwd;
            dst_out         <= dst_in;
            mem_read_out    <= mem_read_in;
            mem_write_out   <= mem_write_in;
            WB_en_out       <= WB_en_in;
        end
    end

endmodule

// File: tb/tb_arm_execute_stage.sv
// Directed bench for arm_execute_stage with hand-computed expectations.
module tb_arm_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, instruction_in, val_Rn_in, val_Rm_in;
    logic [31:0] MEM_stage_val, WB_stage_val;
    logic [1:0]  sel_src1, sel_src2;
    logic [3:0]  EX_command, SR_in;
    logic        imm;
    logic [11:0] shifter_operand;
    logic [23:0] signed_immediate;
    logic        mem_read_in, mem_write_in, WB_en_in, B_in;
    logic [3:0]  dst_in;
    logic [31:0] ALU_res, branch_address, pc_out, instruction_out;
    logic [31:0] ALU_res_out, val_Rm_out;
    logic [3:0]  SR_out, dst_out;
    logic        B_out, mem_read_out, mem_write_out, WB_en_out;

    int checks = 0;
    int errors = 0;

    arm_execute_stage #(.REG_FILE_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instruction_in(instruction_in),
        .val_Rn_in(val_Rn_in), .val_Rm_in(val_Rm_in),
        .MEM_stage_val(MEM_stage_val), .WB_stage_val(WB_stage_val),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .EX_command(EX_command),
        .SR_in(SR_in), .imm(imm), .shifter_operand(shifter_operand),
        .signed_immediate(signed_immediate), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .WB_en_in(WB_en_in), .B_in(B_in),
        .dst_in(dst_in), .ALU_res(ALU_res), .SR_out(SR_out),
        .branch_address(branch_address), .B_out(B_out), .pc_out(pc_out),
        .instruction_out(instruction_out), .ALU_res_out(ALU_res_out),
        .val_Rm_out(val_Rm_out), .dst_out(dst_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .WB_en_out(WB_en_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        pc_in = 0; instruction_in = 0; val_Rn_in = 0; val_Rm_in = 0;
        MEM_stage_val = 0; WB_stage_val = 0; sel_src1 = 0; sel_src2 = 0;
        EX_command = 0; SR_in = 0; imm = 0; shifter_operand = 0;
        signed_immediate = 0; mem_read_in = 0; mem_write_in = 0;
        WB_en_in = 0; B_in = 0; dst_in = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, "_pc"}, pc_out, 32'h0);
        chk({tag, "_instr"}, instruction_out, 32'h0);
        chk({tag, "_alu"}, ALU_res_out, 32'h0);
        chk({tag, "_rm"}, val_Rm_out, 32'h0);
        chk({tag, "_dst"}, {28'b0, dst_out}, 32'h0);
        chk({tag, "_ctl"}, {29'b0, mem_read_out, mem_write_out, WB_en_out}, 32'h0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        pc_in = $urandom; instruction_in = $urandom;
        val_Rn_in = $urandom; val_Rm_in = $urandom;
        EX_command = 4'b0010; dst_in = 4'hF;
        mem_read_in = 1; mem_write_in = 1; WB_en_in = 1;
        step();
        chk_regs_zero("reset");

        // MOV rotated immediate: 0xFF ror 4
        rst = 1'b0;
        clear_inputs();
        pc_in = 32'h0000_0040; instruction_in = 32'hE3A0_12FF;
        imm = 1; shifter_operand = 12'h2FF; EX_command = 4'b0001;
        SR_in = 4'b0011; WB_en_in = 1; dst_in = 4'hA;
        #1;
        chk("mov_imm_res", ALU_res, 32'hF000_000F);
        chk("mov_imm_sr", {28'b0, SR_out}, 32'hB);
        step();
        chk("mov_imm_res_q", ALU_res_out, 32'hF000_000F);
        chk("mov_pc_q", pc_out, 32'h0000_0040);
        chk("mov_instr_q", instruction_out, 32'hE3A0_12FF);
        chk("mov_dst_q", {28'b0, dst_out}, 32'hA);
        chk("mov_wb_q", {31'b0, WB_en_out}, 32'h1);

        // ADD signed overflow
        clear_inputs();
        val_Rn_in = 32'h7FFF_FFFF; val_Rm_in = 32'h1; EX_command = 4'b0010;
        #1;
        chk("add_ovf_res", ALU_res, 32'h8000_0000);
        chk("add_ovf_sr", {28'b0, SR_out}, 32'h9);
        step();

        // SUB with both operands forwarded
        clear_inputs();
        val_Rn_in = 32'd99; val_Rm_in = 32'd77;
        sel_src1 = 2'b01; MEM_stage_val = 32'd5;
        sel_src2 = 2'b10; WB_stage_val = 32'd5;
        EX_command = 4'b0100;
        #1;
        chk("sub_fwd_res", ALU_res, 32'h0);
        chk("sub_fwd_sr", {28'b0, SR_out}, 32'h6);
        step();
        chk("sub_fwd_rm_q", val_Rm_out, 32'd5);

        // ASR by 4
        clear_inputs();
        val_Rm_in = 32'h8000_0000; shifter_operand = 12'h240;
        EX_command = 4'b0001;
        #1;
        chk("asr_res", ALU_res, 32'hF800_0000);
        chk("asr_sr", {28'b0, SR_out}, 32'h8);
        step();

        // LDR address: offset overrides register shift
        clear_inputs();
        val_Rn_in = 32'h100; val_Rm_in = 32'hDEAD; mem_read_in = 1;
        shifter_operand = 12'h004; EX_command = 4'b0010;
        #1;
        chk("ldr_res", ALU_res, 32'h104);
        step();
        chk("ldr_res_q", ALU_res_out, 32'h104);
        chk("ldr_rd_q", {31'b0, mem_read_out}, 32'h1);
        chk("ldr_rm_q", val_Rm_out, 32'hDEAD);

        // Backward branch
        clear_inputs();
        pc_in = 32'h20; signed_immediate = 24'hFFFFFE; B_in = 1;
        #1;
        chk("br_addr", branch_address, 32'h18);
        chk("br_b", {31'b0, B_out}, 32'h1);
        step();

        // SBC with C=0 borrows one more
        clear_inputs();
        val_Rn_in = 32'd5; val_Rm_in = 32'd5; EX_command = 4'b0101;
        #1;
        chk("sbc_res", ALU_res, 32'hFFFF_FFFF);
        chk("sbc_sr", {28'b0, SR_out}, 32'h8);
        step();

        // Undefined opcode
        clear_inputs();
        val_Rn_in = 32'h1234; EX_command = 4'b0000; SR_in = 4'b0101;
        #1;
        chk("nop_res", ALU_res, 32'h0);
        chk("nop_sr", {28'b0, SR_out}, 32'h5);
        step();

        // MVN of ROR by 4
        clear_inputs();
        val_Rm_in = 32'h0000_000F; shifter_operand = 12'h260;
        EX_command = 4'b1001; SR_in = 4'b0010;
        #1;
        chk("mvn_ror_res", ALU_res, 32'h0FFF_FFFF);
        chk("mvn_ror_sr", {28'b0, SR_out}, 32'h2);
        step();

        // sel=11 uses the register value; EOR with immediate
        clear_inputs();
        sel_src1 = 2'b11; val_Rn_in = 32'd3; MEM_stage_val = 32'd100;
        imm = 1; shifter_operand = 12'h006; EX_command = 4'b1000;
        mem_write_in = 1'b0;
        #1;
        chk("eor_sel3_res", ALU_res, 32'd5);
        step();

        // Store path: mem_write and forwarded store data
        clear_inputs();
        mem_write_in = 1; sel_src2 = 2'b01; MEM_stage_val = 32'hCAFE_F00D;
        val_Rm_in = 32'h1111; val_Rn_in = 32'h200; shifter_operand = 12'h008;
        EX_command = 4'b0010;
        #1;
        chk("str_res", ALU_res, 32'h208);
        step();
        chk("str_wr_q", {31'b0, mem_write_out}, 32'h1);
        chk("str_rm_q", val_Rm_out, 32'hCAFE_F00D);

        // Reset again with live inputs
        rst = 1'b1;
        pc_in = 32'h55; dst_in = 4'h7; WB_en_in = 1; mem_read_in = 1;
        step();
        chk_regs_zero("reset2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
